// File: rtl/crc_fsk_pkg.sv
// Shared types and constants for the CRC-8/2FSK link controller.
// Holds the FSM state enum and the default frame/latency sizing.
package crc_fsk_pkg;

  localparam int CODEWORD_W    = 16;
  localparam int SYM_IDX_W     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int RX_LAT_DEF    = 8;
  localparam int MAX_RETRY_DEF = 3;
  localparam int RETRY_W_DEF   = 2;
  localparam int STAT_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SEND,
    SETTLE,
    CHECK,
    DELIVER
  } link_state_e;

endpackage

// File: rtl/crc_link_stats.sv
// Saturating delivery/retry counters for the link controller.
// Present only in builds with CRC_LINK_STATS_EN defined.
module crc_link_stats
  import crc_fsk_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              ok_inc,
  input  logic              fail_inc,
  input  logic              retry_inc,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_fail,
  output logic [STAT_W-1:0] stat_retry
);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      stat_ok    <= '0;
      stat_fail  <= '0;
      stat_retry <= '0;
    end else begin
      if (ok_inc && stat_ok != '1)
        stat_ok <= stat_ok + 1'b1;
      if (fail_inc && stat_fail != '1)
        stat_fail <= stat_fail + 1'b1;
      if (retry_inc && stat_retry != '1)
        stat_retry <= stat_retry + 1'b1;
    end
  end

endmodule

// File: rtl/crc_fsk_link_ctrl.sv
// Frame controller for the CRC-8/2FSK loopback link with CRC retry.
// Define CRC_LINK_STATS_EN to add the stat_ok/stat_fail/stat_retry outputs.
module crc_fsk_link_ctrl
  import crc_fsk_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SYM_PER_FRAME = CODEWORD_W,
  parameter int RX_LAT        = RX_LAT_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF,
  parameter int RETRY_W       = RETRY_W_DEF
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_W-1:0]    tx_data,
  output logic                 tx_ready,
  input  logic                 sym_tick,
  input  logic [SYM_IDX_W-1:0] sign_cnt,
  output logic [DATA_W-1:0]    link_data,
  output logic                 link_active,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_crc_ok,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_err,
  output logic [RETRY_W-1:0]   out_retries,
  input  logic                 out_ready
`ifdef CRC_LINK_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_ok,
  output logic [STAT_W-1:0]    stat_fail,
  output logic [STAT_W-1:0]    stat_retry
`endif
);

  localparam int SYM_W = $clog2(SYM_PER_FRAME);
  localparam int LAT_W = $clog2(RX_LAT + 1);
  localparam logic [SYM_W-1:0]   SYM_LAST  = SYM_W'(SYM_PER_FRAME - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(RX_LAT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  link_state_e        state;
  logic [SYM_W-1:0]   sym_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               last_try;

  assign last_try = (retry_cnt == RETRY_MAX);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b0;
      link_data   <= '0;
      link_active <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_retries <= '0;
      sym_cnt     <= '0;
      lat_cnt     <= '0;
      retry_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            link_data   <= tx_data;
            retry_cnt   <= '0;
            link_active <= 1'b1;
            tx_ready    <= 1'b0;
            state       <= ALIGN;
          end
        end
        ALIGN: begin
          // frames always start on the codeword bit-0 boundary
          if (sym_tick && sign_cnt == '0) begin
            sym_cnt <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (sym_tick) begin
            if (sym_cnt == SYM_LAST) begin
              lat_cnt <= '0;
              state   <= SETTLE;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (lat_cnt == LAT_LAST)
            state <= CHECK;
          else
            lat_cnt <= lat_cnt + 1'b1;
        end
        CHECK: begin
          if (rx_crc_ok || last_try) begin
            out_data    <= rx_data;
            out_err     <= !rx_crc_ok;
            out_retries <= retry_cnt;
            out_valid   <= 1'b1;
            link_active <= 1'b0;
            state       <= DELIVER;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= ALIGN;
          end
        end
        DELIVER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            tx_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC_LINK_STATS_EN
  logic in_check;

  assign in_check = (state == CHECK);

  crc_link_stats u_stats (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .ok_inc     (in_check && rx_crc_ok),
    .fail_inc   (in_check && !rx_crc_ok && last_try),
    .retry_inc  (in_check && !rx_crc_ok && !last_try),
    .stat_ok    (stat_ok),
    .stat_fail  (stat_fail),
    .stat_retry (stat_retry)
  );
`endif

endmodule

// File: tb/tb_crc_fsk_link_ctrl.sv
// Self-checking bench for crc_fsk_link_ctrl: table vectors, random bytes,
// backpressure and mid-frame reset sequences.
module tb_crc_fsk_link_ctrl;

  localparam int RX_LAT    = 8;
  localparam int MAX_RETRY = 3;
  localparam int TICK_P    = 3;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       sym_tick = 1'b0;
  logic [3:0] sign_cnt = 4'd0;
  logic [7:0] link_data;
  logic       link_active;
  logic [7:0] rx_data = 8'h00;
  logic       rx_crc_ok = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_err;
  logic [1:0] out_retries;
  logic       out_ready = 1'b0;
`ifdef CRC_LINK_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_fail;
  logic [15:0] stat_retry;
`endif

  int errors = 0;
  int checks = 0;
  int gdiv = 0;
  int n_ok = 0;
  int n_fail = 0;
  int n_retry = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] okm;
    logic [7:0] bad;
    int         hold;
    logic       noise;
    logic [7:0] exp_data;
    logic       exp_err;
    logic [1:0] exp_retries;
  } vec_t;

  vec_t vecs[5];

  crc_fsk_link_ctrl dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .sym_tick    (sym_tick),
    .sign_cnt    (sign_cnt),
    .link_data   (link_data),
    .link_active (link_active),
    .rx_data     (rx_data),
    .rx_crc_ok   (rx_crc_ok),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_retries (out_retries),
    .out_ready   (out_ready)
`ifdef CRC_LINK_STATS_EN
    ,
    .stat_ok     (stat_ok),
    .stat_fail   (stat_fail),
    .stat_retry  (stat_retry)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // one clock; symbol source advances sign_cnt on each tick
  task automatic step();
    @(posedge sys_clk);
    #1;
    gdiv = (gdiv + 1) % TICK_P;
    sym_tick = (gdiv == 0);
    if (sym_tick) sign_cnt = sign_cnt + 4'd1;
  endtask

  // reference: first attempt with good CRC, else the last allowed attempt
  function automatic int first_ok(input logic [3:0] m);
    int r;
    r = MAX_RETRY;
    for (int i = MAX_RETRY - 1; i >= 0; i--)
      if (m[i]) r = i;
    return r;
  endfunction

  function automatic vec_t make_vec(input logic [7:0] d, input logic [3:0] m,
                                    input logic [7:0] b, input int h,
                                    input logic nz);
    vec_t v;
    int k;
    k = first_ok(m);
    v.data = d;
    v.okm = m;
    v.bad = b;
    v.hold = h;
    v.noise = nz;
    v.exp_retries = 2'(k);
    v.exp_err = !m[k];
    v.exp_data = m[k] ? d : b;
    return v;
  endfunction

  task automatic accept(input logic [7:0] d);
    int g;
    g = 0;
    tx_valid = 1'b1;
    tx_data = d;
    while (!tx_ready && g < 500) begin
      step();
      g++;
    end
    chk("accept_ready", 32'(tx_ready), 32'd1);
    step();
    tx_valid = 1'b0;
    chk("accept_active", 32'(link_active), 32'd1);
    chk("accept_data", 32'(link_data), 32'(d));
  endtask

  task automatic frames(input vec_t v);
    int dk;
    int n;
    int g;
    int badh;
    dk = int'(v.exp_retries);
    for (int k = 0; k <= dk; k++) begin
      g = 0;
      tx_valid = v.noise;
      tx_data = ~v.data;
      while (!(sym_tick && sign_cnt == 4'd0) && g < 200) begin
        if (out_valid || !link_active) badh++;
        step();
        g++;
      end
      if (g >= 200) begin
        chk("align_timeout", 32'(g), 32'd0);
        return;
      end
      step();
      n = 0;
      badh = 0;
      g = 0;
      while (n < 16 && g < 200) begin
        if (link_data !== v.data || !link_active || out_valid || tx_ready)
          badh++;
        if (sym_tick) begin
          n++;
          if (n == 16) begin
            rx_crc_ok = v.okm[k];
            rx_data = v.okm[k] ? v.data : v.bad;
          end
        end
        step();
        g++;
      end
      chk("frame_ticks", 32'(n), 32'd16);
      chk("frame_hold", 32'(badh), 32'd0);
      badh = 0;
      repeat (RX_LAT) begin
        step();
        if (out_valid || !link_active) badh++;
      end
      chk("settle_quiet", 32'(badh), 32'd0);
      step();
      if (k < dk) begin
        chk("retry_no_valid", 32'(out_valid), 32'd0);
        chk("retry_active", 32'(link_active), 32'd1);
      end else begin
        chk("deliver_valid", 32'(out_valid), 32'd1);
        chk("deliver_inactive", 32'(link_active), 32'd0);
        chk("deliver_data", 32'(out_data), 32'(v.exp_data));
        chk("deliver_err", 32'(out_err), 32'(v.exp_err));
        chk("deliver_retries", 32'(out_retries), 32'(v.exp_retries));
        if (v.exp_err) n_fail++;
        else n_ok++;
        n_retry += dk;
      end
    end
  endtask

  task automatic deliver(input vec_t v);
    int badh;
    badh = 0;
    for (int i = 0; i < v.hold; i++) begin
      step();
      if (!out_valid || out_data !== v.exp_data || out_err !== v.exp_err ||
          out_retries !== v.exp_retries || tx_ready)
        badh++;
    end
    chk("deliver_stable", 32'(badh), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tx_valid = 1'b0;
    chk("handshake_drop", 32'(out_valid), 32'd0);
    chk("handshake_idle", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    vec_t w;
    int badh;

    vecs[0] = '{8'hBB, 4'b0001, 8'h00, 0, 1'b0, 8'hBB, 1'b0, 2'd0};
    vecs[1] = '{8'h3C, 4'b0010, 8'h5A, 2, 1'b1, 8'h3C, 1'b0, 2'd1};
    vecs[2] = '{8'hA5, 4'b0000, 8'h00, 1, 1'b0, 8'h00, 1'b1, 2'd3};
    vecs[3] = '{8'h11, 4'b1000, 8'h77, 0, 1'b1, 8'h11, 1'b0, 2'd3};
    vecs[4] = '{8'h7E, 4'b0100, 8'hFF, 3, 1'b0, 8'h7E, 1'b0, 2'd2};

    repeat (3) step();
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_active", 32'(link_active), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_link_data", 32'(link_data), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_retries", 32'(out_retries), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_ready_after", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        while (sign_cnt != 4'd5 || !sym_tick) step();
      end
      accept(vecs[i].data);
      frames(vecs[i]);
      deliver(vecs[i]);
    end

    // backpressure with a new byte waiting
    v = make_vec(8'hC3, 4'b0001, 8'h00, 0, 1'b0);
    w = make_vec(8'h5D, 4'b0011, 8'h12, 0, 1'b0);
    accept(v.data);
    frames(v);
    tx_valid = 1'b1;
    tx_data = w.data;
    badh = 0;
    repeat (20) begin
      step();
      if (!out_valid || out_data !== v.data || tx_ready) badh++;
    end
    chk("bp_hold", 32'(badh), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(tx_ready), 32'd1);
    step();
    tx_valid = 1'b0;
    chk("bp_new_active", 32'(link_active), 32'd1);
    chk("bp_new_data", 32'(link_data), 32'(w.data));
    frames(w);
    deliver(w);

    for (int i = 0; i < 24; i++) begin
      v = make_vec(8'($urandom), 4'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)), 1'($urandom));
      repeat ($urandom_range(0, 40)) step();
      out_ready = 1'($urandom);
      step();
      out_ready = 1'b0;
      chk("idle_no_valid", 32'(out_valid), 32'd0);
      accept(v.data);
      frames(v);
      deliver(v);
    end

`ifdef CRC_LINK_STATS_EN
    chk("stat_ok", 32'(stat_ok), 32'(n_ok));
    chk("stat_fail", 32'(stat_fail), 32'(n_fail));
    chk("stat_retry", 32'(stat_retry), 32'(n_retry));
`endif

    // reset while a frame is in flight
    accept(8'h99);
    while (!(sym_tick && sign_cnt == 4'd0)) step();
    step();
    while (sign_cnt != 4'd9) step();
    reset = 1'b1;
    step();
    chk("mid_rst_ready", 32'(tx_ready), 32'd0);
    chk("mid_rst_active", 32'(link_active), 32'd0);
    chk("mid_rst_link_data", 32'(link_data), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_rst_ready_after", 32'(tx_ready), 32'd1);
    badh = 0;
    rx_crc_ok = 1'b1;
    repeat (100) begin
      step();
      if (out_valid || link_active) badh++;
    end
    chk("mid_rst_no_delivery", 32'(badh), 32'd0);
`ifdef CRC_LINK_STATS_EN
    chk("mid_rst_stats", 32'({stat_ok, stat_fail | stat_retry}), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_fsk_link_ctrl.md
Name: crc_fsk_link_ctrl

Overview:
Frame-level controller for the CRC-8/2FSK loopback link (encoder -> bit writer -> FSK mod/demod -> bit reader -> decoder).
- Accepts bytes from a single requester over a valid/ready handshake and holds each byte on the encoder input for one 16-symbol frame, aligned to the symbol counter wrap.
- Waits for receive-pipeline settle, then samples the decoder result.
- Retries on CRC failure up to MAX_RETRY times, then delivers the byte plus error/retry status over a valid/ready output.

Parameters:
DATA_W, 8, payload width driven to the encoder and read from the decoder
SYM_PER_FRAME, 16, symbol ticks per frame (codeword bits)
RX_LAT, 8, sys_clk cycles between frame end and a valid decoder output
MAX_RETRY, 3, retransmissions allowed after the first attempt
RETRY_W, 2, width of the retry counter; must hold MAX_RETRY

Ports:
sys_clk  in  1  system clock, sole clock
reset  in  1  synchronous, active-high reset
tx_valid  in  1  requester byte valid
tx_data  in  DATA_W  requester byte
tx_ready  out  1  controller can accept a byte
sym_tick  in  1  one-cycle pulse at every symbol boundary (phase wrap)
sign_cnt  in  4  current codeword bit index from the clock generator
link_data  out  DATA_W  byte presented to the CRC encoder
link_active  out  1  a frame is in flight
rx_data  in  DATA_W  decoder data_out
rx_crc_ok  in  1  decoder crc_ok; 1 means the codeword checks good
out_valid  out  1  delivered result valid
out_data  out  DATA_W  delivered byte (last received attempt)
out_err  out  1  1 = all attempts failed CRC
out_retries  out  RETRY_W  retries used for this byte
out_ready  in  1  consumer accepts the result

Behaviour:
Decided: one clock, sys_clk; reset is synchronous, active-high, named reset.

Reset:
- State = IDLE.
- tx_ready=0 during the reset cycle, 1 in the cycle after.
- link_data=0, link_active=0, out_valid=0, out_data=0, out_err=0, out_retries=0.
- All counters cleared.
- Reset mid-frame drops the in-flight byte with no delivery.

FSM (registered state, Moore outputs):
- IDLE: tx_ready=1. On tx_valid&&tx_ready, latch tx_data into link_data, clear retry_cnt, go ALIGN. tx_ready is low in every other state.
- ALIGN: wait for sym_tick&&sign_cnt==0, then go SEND with sym_cnt=0. link_active=1 from entry into ALIGN through CHECK.
- SEND: sym_cnt increments on each sym_tick. On the tick where sym_cnt==SYM_PER_FRAME-1 (end of bit 15), go SETTLE with lat_cnt=0. link_data stays constant.
- SETTLE: lat_cnt increments every cycle; after RX_LAT cycles, go CHECK.
- CHECK (one cycle): sample rx_data/rx_crc_ok.
  - If rx_crc_ok, or retry_cnt==MAX_RETRY: load out_data=rx_data, out_err=!rx_crc_ok, out_retries=retry_cnt; go DELIVER.
  - Otherwise: retry_cnt+1, go ALIGN (next frame starts at the next sign_cnt==0 tick).
- DELIVER: out_valid=1, link_active=0. Hold all out_* stable until out_ready. On out_valid&&out_ready, out_valid drops next cycle and the FSM goes IDLE.

Boundary conditions:
- sym_tick in the same cycle as the IDLE->ALIGN transfer is not used for alignment.
- sym_tick during SETTLE/CHECK is ignored.
- tx_valid outside IDLE is ignored; the requester holds the byte.
- out_ready without out_valid has no effect.
- Total attempts per byte = 1 + MAX_RETRY; retry_cnt never exceeds MAX_RETRY.

Optional Feature:
Macro CRC_LINK_STATS_EN.
- Defined: adds outputs stat_ok[15:0], stat_fail[15:0], stat_retry[15:0], all saturating at 16'hFFFF, cleared by reset.
  - stat_ok increments per delivery with out_err=0.
  - stat_fail increments per delivery with out_err=1.
  - stat_retry increments per CHECK that triggers a retry.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package crc_fsk_pkg: state enum (IDLE, ALIGN, SEND, SETTLE, CHECK, DELIVER), CODEWORD_W=16, SYM_IDX_W=4, default DATA_W/RX_LAT/MAX_RETRY constants.
- One sub-module, crc_link_stats: the three saturating counters, instantiated only under CRC_LINK_STATS_EN.
- The FSM and its counters stay in crc_fsk_link_ctrl.

Test Plan:
- Clean link: tx_data=8'hBB, rx_crc_ok tied 1, rx_data mirrors link_data -> out_valid with out_data=8'hBB, out_err=0, out_retries=0. The first sym_tick is at sign_cnt=0, so out_valid asserts exactly 16 ticks + RX_LAT + 2 cycles after that alignment tick.
- Mid-frame request: tx accepted while sign_cnt=5 -> link_active=1 but SEND not entered until the next sign_cnt==0 tick; link_data stable across all 16 ticks.
- One CRC failure: rx_crc_ok=0 on attempt 1, 1 on attempt 2, tx_data=8'h3C -> out_data=8'h3C, out_err=0, out_retries=1; two frames observed on link_active.
- Persistent failure: rx_crc_ok=0, rx_data=8'h00 -> after 4 frames out_err=1, out_retries=3, out_data=8'h00. With CRC_LINK_STATS_EN: stat_fail=1, stat_retry=3.
- Backpressure: out_ready=0 for 20 cycles -> out_valid/out_data held, tx_ready=0 while a new tx_valid is pending. out_ready=1 -> IDLE next cycle, and the new byte is accepted the cycle after.
- Reset in SEND at sign_cnt=9 -> next cycle all outputs 0, state IDLE, tx_ready=1 the following cycle, no out_valid pulse.
